// File: rtl/dbg_text_pkg.sv
// ---------------------------------------------------------------------------
// dbg_text_pkg
//
// Shared constants and helpers for the debug text overlay. Anything that
// turns binary state into printable characters for the character generator
// pulls its ASCII codes from here so every overlay block agrees on them.
//
// Contents:
//   ASC_SPACE    - 0x20, used for blanked digits and the reset pattern
//   ASC_ZERO     - 0x30, base code for decimal digits 0..9
//   ASC_UPPER_A  - 0x41, base code for hex letters A..F
//   ASC_LOWER_A  - 0x61, base code for hex letters a..f
//   NIB_BITS     - width of one hex digit
//   CHR_BITS     - width of one ASCII character
//   nib_to_ascii - maps one 4-bit digit to its ASCII hex character
// ---------------------------------------------------------------------------
package dbg_text_pkg;

  localparam int NIB_BITS = 4;
  localparam int CHR_BITS = 8;

  localparam logic [7:0] ASC_SPACE   = 8'h20;
  localparam logic [7:0] ASC_ZERO    = 8'h30;
  localparam logic [7:0] ASC_UPPER_A = 8'h41;
  localparam logic [7:0] ASC_LOWER_A = 8'h61;

  // Every one of the 16 codes lands on a printable character, so there is
  // no default branch that could leak X into the overlay.
  function automatic logic [7:0] nib_to_ascii(input logic [3:0] nib,
                                              input logic       upper);
    logic [7:0] letterBase;
    letterBase = upper ? ASC_UPPER_A : ASC_LOWER_A;
    if (nib < 4'd10) begin
      return ASC_ZERO + {4'h0, nib};
    end
    return letterBase + {4'h0, nib - 4'd10};
  endfunction

endpackage

// File: rtl/hex_digit.sv
// ---------------------------------------------------------------------------
// hex_digit
//
// Purely combinational converter for one hex digit. Produces the ASCII code
// for the digit, or a space when the caller asks for it to be blanked.
//
// Parameters:
//   UPPERCASE - 1: letters map to 'A'..'F', 0: letters map to 'a'..'f'
//
// Ports:
//   nib   in   4  binary digit value
//   blank in   1  force the output to a space
//   ascii out  8  ASCII character for this digit
// ---------------------------------------------------------------------------
module hex_digit
  import dbg_text_pkg::*;
#(
  parameter bit UPPERCASE = 1'b1
) (
  input  logic [3:0] nib,
  input  logic       blank,
  output logic [7:0] ascii
);

  logic [7:0] w_code;

  // The conversion itself lives in the package so other overlay blocks
  // produce identical characters; this module only adds the blank override.
  always_comb begin
    w_code = nib_to_ascii(nib, UPPERCASE);
    ascii  = blank ? ASC_SPACE : w_code;
  end

endmodule

// File: rtl/int_to_hex.sv
// ---------------------------------------------------------------------------
// int_to_hex
//
// Clocked nibble-to-ASCII hex encoder for the debug text overlay. Converts a
// packed value of NIBBLES hex digits into one ASCII byte per digit, with
// optional leading-zero blanking. Result appears one cycle after the load.
//
// Parameters:
//   NIBBLES   - number of hex digits converted in parallel (1..8)
//   UPPERCASE - 1: letters 'A'..'F', 0: letters 'a'..'f'
//
// Ports:
//   clk      in   1            system clock, rising edge
//   rst      in   1            synchronous active-high reset
//   en       in   1            load strobe, samples value and blank_lz
//   value    in   4*NIBBLES    binary value, digit 0 in the low nibble
//   blank_lz in   1            suppress leading zero digits for this load
//   chr      out  8*NIBBLES    ASCII characters, byte i encodes digit i
//   valid    out  1            high once chr holds a converted value
// ---------------------------------------------------------------------------
module int_to_hex
  import dbg_text_pkg::*;
#(
  parameter int NIBBLES   = 1,
  parameter bit UPPERCASE = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [NIB_BITS*NIBBLES-1:0] value,
  input  logic                      blank_lz,
  output logic [CHR_BITS*NIBBLES-1:0] chr,
  output logic                      valid
);

  logic [NIBBLES-1:0]          w_blank;
  logic                        w_seenNonZero;
  logic [CHR_BITS*NIBBLES-1:0] w_chr;

  logic [CHR_BITS*NIBBLES-1:0] r_chr;
  logic                        r_valid;

  // Leading-zero scan from the most significant digit down. Once any
  // non-zero digit has been seen, every lower digit is printed. Digit 0 is
  // left out of the loop so its blank flag stays 0, which makes an all-zero
  // value show a single '0' instead of an empty field.
  always_comb begin
    w_blank       = '0;
    w_seenNonZero = 1'b0;
    for (int i = NIBBLES - 1; i >= 1; i--) begin
      w_seenNonZero = w_seenNonZero | (value[NIB_BITS*i +: NIB_BITS] != 4'h0);
      w_blank[i]    = blank_lz & ~w_seenNonZero;
    end
  end

  // One combinational converter per digit.
  for (genvar g = 0; g < NIBBLES; g++) begin : gDigit
    hex_digit #(
      .UPPERCASE(UPPERCASE)
    ) uDigit (
      .nib  (value[NIB_BITS*g +: NIB_BITS]),
      .blank(w_blank[g]),
      .ascii(w_chr[CHR_BITS*g +: CHR_BITS])
    );
  end

  // Output register bank and valid flag. Reset wins over a same-cycle load,
  // and the outputs hold whenever en is low. valid is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_chr   <= {NIBBLES{ASC_SPACE}};
      r_valid <= 1'b0;
    end else if (en) begin
      r_chr   <= w_chr;
      r_valid <= 1'b1;
    end
  end

  assign chr   = r_chr;
  assign valid = r_valid;

endmodule

// File: tb/tb_int_to_hex.sv
// ---------------------------------------------------------------------------
// tb_int_to_hex
//
// Self-checking bench for int_to_hex. Three instances share clock, reset,
// enable and blank control:
//   dut4 - NIBBLES=4, uppercase (blanking, reset, hold, priority)
//   dut1 - NIBBLES=1, uppercase (full digit sweep)
//   dutL - NIBBLES=1, lowercase (lowercase letter mapping)
// A table of hand-computed vectors is applied back to back, followed by
// hand-written sequences for reset, hold and reset/enable priority.
// ---------------------------------------------------------------------------
module tb_int_to_hex;

  logic        clk;
  logic        rst;
  logic        en;
  logic        blankLz;
  logic [15:0] value4;
  logic [3:0]  value1;

  logic [31:0] chr4;
  logic        valid4;
  logic [7:0]  chr1;
  logic        valid1;
  logic [7:0]  chrL;
  logic        validL;

  int compareCount;
  int mismatchCount;

  typedef struct {
    logic        blank;
    logic [15:0] v4;
    logic [31:0] exp4;
    logic [3:0]  v1;
    logic [7:0]  exp1;
    logic [7:0]  expL;
  } vector_t;

  vector_t vecs[16];

  int_to_hex #(.NIBBLES(4), .UPPERCASE(1'b1)) dut4 (
    .clk(clk), .rst(rst), .en(en), .value(value4), .blank_lz(blankLz),
    .chr(chr4), .valid(valid4)
  );

  int_to_hex #(.NIBBLES(1), .UPPERCASE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .value(value1), .blank_lz(blankLz),
    .chr(chr1), .valid(valid1)
  );

  int_to_hex #(.NIBBLES(1), .UPPERCASE(1'b0)) dutL (
    .clk(clk), .rst(rst), .en(en), .value(value1), .blank_lz(blankLz),
    .chr(chrL), .valid(validL)
  );

  // Free-running 10 time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs, then step just past the rising edge so the
  // registered outputs can be sampled away from the edge.
  task automatic applyStimulus(input logic        rstIn,
                               input logic        enIn,
                               input logic        blankIn,
                               input logic [15:0] v4In,
                               input logic [3:0]  v1In);
    rst     = rstIn;
    en      = enIn;
    blankLz = blankIn;
    value4  = v4In;
    value1  = v1In;
    @(posedge clk);
    #1;
  endtask

  // Single comparison with failure reporting.
  task automatic checkOutput(input string       name,
                             input logic [31:0] actual,
                             input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    rst     = 1'b0;
    en      = 1'b0;
    blankLz = 1'b0;
    value4  = '0;
    value1  = '0;

    // blank, v4, exp4, v1, exp1 (upper), expL (lower)
    vecs[0]  = '{1'b1, 16'h00A5, 32'h20204135, 4'h0, 8'h30, 8'h30};
    vecs[1]  = '{1'b1, 16'h0000, 32'h20202030, 4'h1, 8'h31, 8'h31};
    vecs[2]  = '{1'b1, 16'h1000, 32'h31303030, 4'h2, 8'h32, 8'h32};
    vecs[3]  = '{1'b0, 16'h00A5, 32'h30304135, 4'h3, 8'h33, 8'h33};
    vecs[4]  = '{1'b0, 16'h12AF, 32'h31324146, 4'h4, 8'h34, 8'h34};
    vecs[5]  = '{1'b1, 16'h0B0C, 32'h20423043, 4'h5, 8'h35, 8'h35};
    vecs[6]  = '{1'b1, 16'h000F, 32'h20202046, 4'h6, 8'h36, 8'h36};
    vecs[7]  = '{1'b0, 16'h0000, 32'h30303030, 4'h7, 8'h37, 8'h37};
    vecs[8]  = '{1'b1, 16'hFFFF, 32'h46464646, 4'h8, 8'h38, 8'h38};
    vecs[9]  = '{1'b1, 16'h0001, 32'h20202031, 4'h9, 8'h39, 8'h39};
    vecs[10] = '{1'b1, 16'h0100, 32'h20313030, 4'hA, 8'h41, 8'h61};
    vecs[11] = '{1'b0, 16'hDEAD, 32'h44454144, 4'hB, 8'h42, 8'h62};
    vecs[12] = '{1'b1, 16'hBEEF, 32'h42454546, 4'hC, 8'h43, 8'h63};
    vecs[13] = '{1'b1, 16'h0090, 32'h20203930, 4'hD, 8'h44, 8'h64};
    vecs[14] = '{1'b1, 16'h7000, 32'h37303030, 4'hE, 8'h45, 8'h65};
    vecs[15] = '{1'b1, 16'h0A0B, 32'h20413042, 4'hF, 8'h46, 8'h66};

    // Reset held for two cycles with en high: load must be dropped.
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h12AF, 4'h7);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h12AF, 4'h7);
    checkOutput("reset chr4",   chr4,            32'h20202020);
    checkOutput("reset valid4", {31'b0, valid4}, 32'h0);
    checkOutput("reset chr1",   {24'b0, chr1},   32'h20);
    checkOutput("reset validL", {31'b0, validL}, 32'h0);

    // Idle cycle after reset: nothing loaded yet.
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h5555, 4'h5);
    checkOutput("idle chr4",   chr4,            32'h20202020);
    checkOutput("idle valid4", {31'b0, valid4}, 32'h0);

    // First load after reset.
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h12AF, 4'h3);
    checkOutput("first load chr4",   chr4,            32'h31324146);
    checkOutput("first load valid4", {31'b0, valid4}, 32'h1);
    checkOutput("first load chr1",   {24'b0, chr1},   32'h33);

    // Table sweep, one load per cycle.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b1, vecs[i].blank, vecs[i].v4, vecs[i].v1);
      checkOutput($sformatf("vec%0d chr4", i), chr4, vecs[i].exp4);
      checkOutput($sformatf("vec%0d chr1", i), {24'b0, chr1}, {24'b0, vecs[i].exp1});
      checkOutput($sformatf("vec%0d chrL", i), {24'b0, chrL}, {24'b0, vecs[i].expL});
      checkOutput($sformatf("vec%0d valid4", i), {31'b0, valid4}, 32'h1);
    end

    // Hold: load FFFF, then en low for 5 cycles while inputs wander.
    applyStimulus(1'b0, 1'b1, 1'b0, 16'hFFFF, 4'hC);
    checkOutput("hold load chr4", chr4, 32'h46464646);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, i[0], 16'h0101 * 16'(i + 1), 4'(i));
      checkOutput($sformatf("hold%0d chr4", i), chr4, 32'h46464646);
      checkOutput($sformatf("hold%0d chr1", i), {24'b0, chr1}, 32'h43);
      checkOutput($sformatf("hold%0d valid4", i), {31'b0, valid4}, 32'h1);
    end

    // Reset and enable on the same edge: reset wins.
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h1234, 4'h9);
    checkOutput("prio chr4",   chr4,            32'h20202020);
    checkOutput("prio valid4", {31'b0, valid4}, 32'h0);
    checkOutput("prio chrL",   {24'b0, chrL},   32'h20);

    // First load after the mid-stream reset behaves normally.
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0042, 4'hE);
    checkOutput("post reset chr4",   chr4,            32'h20203432);
    checkOutput("post reset valid4", {31'b0, valid4}, 32'h1);
    checkOutput("post reset chrL",   {24'b0, chrL},   32'h65);
    checkOutput("post reset validL", {31'b0, validL}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/int_to_hex.md
# int_to_hex

Clocked nibble-to-ASCII hex encoder for the debug text overlay. Converts a packed binary value of `NIBBLES` 4-bit digits into printable ASCII hex characters, one byte per digit, for the character generator to place into on-screen register dumps (A, BC, DE, HL, SP, PC, SCX/SCY, breakpoint address). The output is registered with one cycle of latency. Optional leading-zero blanking replaces suppressed digits with spaces.

## Interface
Parameters:
- `NIBBLES`, default 1: number of hex digits converted in parallel (1..8).
- `UPPERCASE`, default 1: 1 maps digits A–F to 0x41–0x46; 0 maps them to 0x61–0x66.

Ports:
- `clk`  input  1: system clock. There is one clock domain; all state updates on the rising edge.
- `rst`  input  1: synchronous, active-high reset.
- `en`  input  1: load strobe. Samples `value` and `blank_lz` on this edge.
- `value`  input  4*NIBBLES: binary value. Digit i is `value[4i+3:4i]`; digit 0 is the least significant.
- `blank_lz`  input  1: enables leading-zero suppression for this load.
- `chr`  output  8*NIBBLES: ASCII characters. Byte i, `chr[8i+7:8i]`, encodes digit i.
- `valid`  output  1: high once `chr` holds a converted value.

## Operation
- Per-digit mapping:
  - 0–9 map to 0x30–0x39.
  - 10–15 map to 0x41–0x46 when UPPERCASE=1, or 0x61–0x66 when UPPERCASE=0.
- All 16 codes are defined. There is no X or default-case output.
- Leading-zero blanking (only when `blank_lz`=1 at load):
  - Scan from the most significant digit downward. Each contiguous zero digit is output as 0x20 (space) until the first non-zero digit.
  - Digit 0 is never blanked, so a value of 0 shows as `   0`.
- Blanking is evaluated on the sampled `value` only. There is no dependency on previous loads.
- When `en`=0, `chr` and `valid` hold their values.
- There are no handshakes or back-pressure. A load is accepted on every cycle that `en`=1.

## Timing
- Latency: 1 cycle. If `en`=1 at edge k, `chr`/`valid` reflect that `value` after edge k.
- Throughput: 1 conversion per cycle. Back-to-back `en` pulses each produce a result on the following cycle.
- Reset values:
  - `chr` = 0x20 in every byte (all spaces).
  - `valid` = 0.
- Reset has priority over `en` on the same edge: after that edge the outputs are the reset values and the load is dropped.
- Reset applied mid-stream clears outputs on that edge. The first `en` after reset deasserts loads normally.
- `valid` goes to 1 on the first load after reset and stays 1 until the next reset.
- Outputs are driven only from flops. There is no combinational path from inputs to `chr`.

## Structure
- Shared package `dbg_text_pkg`:
  - ASCII constants `ASC_SPACE` (0x20), `ASC_ZERO` (0x30), `ASC_UPPER_A` (0x41), `ASC_LOWER_A` (0x61).
  - A function or localparam table for nibble-to-ASCII conversion, parameterized by case.
- Sub-module `hex_digit`: purely combinational, maps a 4-bit `nib` plus a `blank` flag to an 8-bit ASCII code. It is instantiated `NIBBLES` times in a generate loop.
- Top level contains:
  - the leading-zero scan, a MSB-to-LSB "seen non-zero" chain producing the per-digit `blank` flags with digit 0's flag forced to 0;
  - the output register bank;
  - the `valid` flop.

## Test plan
- Reset: assert `rst` for 2 cycles with `en`=1 and NIBBLES=4 → `chr`=0x20202020 and `valid`=0. First load after release (`value`=0x12AF, `blank_lz`=0) → next cycle `chr`="12AF" (0x31324146), `valid`=1.
- Exhaustive digit sweep, NIBBLES=1, UPPERCASE=1: `value`=0..15 on consecutive cycles → `chr` goes 0x30..0x39 then 0x41..0x46, each one cycle after its input.
- Lowercase build, UPPERCASE=0: `value`=0xB → `chr`=0x62. `value`=0x9 → `chr`=0x39.
- Leading-zero blanking, NIBBLES=4, `blank_lz`=1:
  - 0x00A5 → "  A5" (0x20204135).
  - 0x0000 → "   0" (0x20202030).
  - 0x1000 → "1000".
  - With `blank_lz`=0, 0x00A5 → "00A5".
- Hold and priority:
  - Load 0xFFFF, then hold `en`=0 for 5 cycles with `value` changing → `chr` stays "FFFF".
  - Assert `rst` and `en` together → outputs return to the reset values.
